// File: rtl/fa_serial_ctrl_if.sv
//------------------------------------------------------------------------------
// fa_serial_ctrl_if : operand/result valid-ready bundle for fa_serial_ctrl
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface fa_serial_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             busy;

  modport master (
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, sum, co, busy
  );

  modport slave (
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, sum, co, busy
  );
endinterface

`default_nettype wire

// File: rtl/fa_serial_ctrl.sv
//------------------------------------------------------------------------------
// fa_serial_ctrl : bit-serial WIDTH-bit adder sequencing a single full adder
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module fa (
  input  wire logic i_a,
  input  wire logic i_b,
  input  wire logic i_ci,
  output logic      o_s,
  output logic      o_co
);
  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module fa_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  wire logic        clk,
  input  wire logic        rst,
  fa_serial_ctrl_if.slave  bus
);
  localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_sum_sr;
  logic               r_carry;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_out_valid;
  logic               r_busy;

  logic               w_s;
  logic               w_co;
  logic [WIDTH-1:0]   w_sum_next;
  logic               w_accept;

  fa u_fa (
    .i_a  (r_a_sr[0]),
    .i_b  (r_b_sr[0]),
    .i_ci (r_carry),
    .o_s  (w_s),
    .o_co (w_co)
  );

  // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at index 0.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign w_sum_next = w_s;
    end else begin : g_sum_wn
      assign w_sum_next = {w_s, r_sum_sr[WIDTH-1:1]};
    end
  endgenerate

  assign bus.in_ready  = (r_state == S_IDLE) & ~rst;
  assign w_accept      = bus.in_valid & bus.in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum_sr;
  assign bus.co        = r_carry;
  assign bus.busy      = r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a_sr      <= '0;
      r_b_sr      <= '0;
      r_sum_sr    <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a_sr  <= bus.a;
            r_b_sr  <= bus.b;
            r_carry <= bus.ci;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum_sr <= w_sum_next;
          r_carry  <= w_co;
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          if (r_cnt == c_last) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_fa_serial_ctrl.sv
//------------------------------------------------------------------------------
// tb_fa_serial_ctrl : scoreboard bench for WIDTH=8 and WIDTH=1 builds
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_fa_serial_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic rst1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   done1 = 1'b0;

  bit   rdy_rand = 1'b0;
  logic rdy_fix  = 1'b1;

  int   exp_q[$];
  int   lat_q[$];
  int   exp1_q[$];
  int   lat1_q[$];

  fa_serial_ctrl_if #(.WIDTH(W)) bus8 ();
  fa_serial_ctrl_if #(.WIDTH(1)) bus1 ();

  fa_serial_ctrl #(.WIDTH(W)) dut8 (.clk(clk), .rst(rst),  .bus(bus8));
  fa_serial_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // out_ready drivers change just after the rising edge
  initial forever begin
    @(posedge clk);
    #1;
    bus8.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
    bus1.out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send8(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input int junk);
    int waited = 0;
    bus8.a = a; bus8.b = b; bus8.ci = ci; bus8.in_valid = 1'b1;
    @(negedge clk);
    while (!bus8.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus8.in_ready) begin
      timeout_fail("accept8");
      bus8.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(int'(a) + int'(b) + int'(ci));
    lat_q.push_back(cyc + 1 + W);
    @(posedge clk); #1;
    for (int i = 0; i < junk; i++) begin
      bus8.a = W'($urandom); bus8.b = W'($urandom); bus8.ci = 1'($urandom);
      @(posedge clk); #1;
    end
    bus8.in_valid = 1'b0;
  endtask

  task automatic send1(input logic a, input logic b, input logic ci);
    int waited = 0;
    bus1.a = a; bus1.b = b; bus1.ci = ci; bus1.in_valid = 1'b1;
    @(negedge clk);
    while (!bus1.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus1.in_ready) begin
      timeout_fail("accept1");
      bus1.in_valid = 1'b0;
      return;
    end
    exp1_q.push_back(int'(a) + int'(b) + int'(ci));
    lat1_q.push_back(cyc + 2);
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
  endtask

  task automatic drain8();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) timeout_fail("drain8");
    repeat (3) @(posedge clk);
    #1;
  endtask

  // WIDTH=8 monitor: result, latency, hold stability, return to IDLE
  initial begin
    logic prev_ov = 1'b0;
    bit   exp_idle = 1'b0;
    int   cur_exp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ov  = 1'b0;
        exp_idle = 1'b0;
      end else begin
        if (exp_idle) begin
          chk("idle_after_handshake", {bus8.in_ready, bus8.out_valid}, 2'b10);
          exp_idle = 1'b0;
        end
        if (bus8.out_valid) begin
          if (!prev_ov) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_out_valid: got sum %0h co %0b with no pending op", bus8.sum, bus8.co);
            end else begin
              cur_exp = exp_q.pop_front();
              chk("result8", {bus8.co, bus8.sum}, 64'(cur_exp));
              chk("latency8", 64'(cyc), 64'(lat_q.pop_front()));
            end
          end else begin
            chk("hold_stable8", {bus8.co, bus8.sum}, 64'(cur_exp));
          end
          chk("in_ready_low_done", bus8.in_ready, 0);
          chk("busy_done", bus8.busy, 1);
          if (bus8.out_ready) exp_idle = 1'b1;
        end
        prev_ov = bus8.out_valid;
      end
    end
  end

  // WIDTH=1 monitor
  initial begin
    logic prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (rst1) begin
        prev_ov = 1'b0;
      end else begin
        if (bus1.out_valid && !prev_ov) begin
          if (exp1_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid1: got sum %0b co %0b", bus1.sum, bus1.co);
          end else begin
            chk("result1", {bus1.co, bus1.sum}, 64'(exp1_q.pop_front()));
            chk("latency1", 64'(cyc), 64'(lat1_q.pop_front()));
          end
        end
        prev_ov = bus1.out_valid;
      end
    end
  end

  // WIDTH=1 stimulus
  initial begin
    int n = 0;
    rst1 = 1'b1;
    bus1.in_valid = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0; bus1.ci = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst1 = 1'b0;
    send1(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 1000; i++)
      send1(1'($urandom), 1'($urandom), 1'($urandom));
    while (exp1_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (exp1_q.size() != 0) timeout_fail("drain1");
    done1 = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // WIDTH=8 stimulus
  initial begin
    int n;
    rst = 1'b1;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.ci = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {bus8.in_ready, bus8.out_valid, bus8.busy, bus8.co, bus8.sum}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", {bus8.in_ready, bus8.busy}, 2'b10);
    @(posedge clk); #1;

    send8(8'hFF, 8'h01, 1'b0, 0);
    send8(8'hA5, 8'h5A, 1'b1, 0);
    send8(8'h12, 8'h34, 1'b0, 0);
    send8(8'h00, 8'h00, 1'b0, 0);
    send8(8'hFF, 8'hFF, 1'b1, 0);
    drain8();

    // backpressure for five cycles after out_valid
    rdy_fix = 1'b0;
    @(posedge clk); #1;
    send8(8'h80, 8'h80, 1'b1, 0);
    n = 0;
    while (!bus8.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus8.out_valid) timeout_fail("wait_out_valid");
    repeat (5) @(negedge clk);
    rdy_fix = 1'b1;
    drain8();

    // operands wiggled with in_valid high while running must be ignored
    send8(8'h3C, 8'hC3, 1'b0, W - 1);
    send8(8'h7F, 8'h01, 1'b1, W - 1);
    drain8();

    // reset during RUN cycle 3
    send8(8'hAB, 8'hCD, 1'b1, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    chk("abort_idle", {bus8.in_ready, bus8.out_valid, bus8.busy, bus8.co, bus8.sum}, {3'b100, 9'h000});
    repeat (W + 4) @(posedge clk);
    #1;
    send8(8'h01, 8'h01, 1'b0, 0);
    drain8();

    // random regression with random backpressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 1000; i++)
      send8(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0) ? W - 1 : 0);
    drain8();
    rdy_rand = 1'b0;

    n = 0;
    while (!done1 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (!done1) timeout_fail("width1_stream");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
